// File: rtl/io_cond_pkg.sv
// Shared definitions for the input-conditioning stages: FSM state encodings and
// default timing constants.
package io_cond_pkg;

    localparam int         DEF_TICK_DIV     = 50000;
    localparam int         DEF_STABLE_TICKS = 10;
    localparam logic [7:0] GLITCH_MAX       = 8'hFF;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } db_state_e;

endpackage

// File: rtl/input_debouncer_tick_prescaler.sv
// Free-running sample-tick generator: one-cycle registered strobe every TICK_DIV clocks,
// first strobe in cycle TICK_DIV after reset release.
module tick_prescaler #(
    parameter int TICK_DIV = io_cond_pkg::DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            tick <= wrap;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for one asynchronous input: synchronizer, tick prescaler, stability-count FSM.
// Optional GLITCH_COUNT_EN adds glitch_clr/glitch_cnt (saturating count of aborted transitions).
module input_debouncer
    import io_cond_pkg::*;
#(
    parameter int   TICK_DIV     = DEF_TICK_DIV,
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int   SYNC_STAGES  = 2,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_async,
`ifdef GLITCH_COUNT_EN
    input  logic       glitch_clr,
    output logic [7:0] glitch_cnt,
`endif
    output logic       db_out,
    output logic       tick,
    output logic       db_change
);

    localparam int CNT_W = $clog2(STABLE_TICKS + 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   db_d, chg_d;
`ifdef GLITCH_COUNT_EN
    logic                   abort;
`endif

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_ff <= {SYNC_STAGES{RESET_LEVEL}};
        else        sync_ff <= {sync_ff[SYNC_STAGES-2:0], din_async};
    end

    assign sync_q  = sync_ff[SYNC_STAGES-1];
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_out;
        chg_d   = 1'b0;
`ifdef GLITCH_COUNT_EN
        abort   = 1'b0;
`endif
        case (state_q)
            ST_STABLE: begin
                if (tick && (sync_q != db_out)) begin
                    if (STABLE_TICKS == 1) begin
                        db_d  = sync_q;
                        chg_d = 1'b1;
                    end else begin
                        state_d = ST_CHECK;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (tick) begin
                    if (sync_q == db_out) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
`ifdef GLITCH_COUNT_EN
                        abort   = 1'b1;
`endif
                    end else if (cnt_inc == CNT_W'(STABLE_TICKS)) begin
                        db_d    = sync_q;
                        chg_d   = 1'b1;
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
            end
            // Any other encoding falls back to STABLE, keeping the current level.
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STABLE;
            cnt_q     <= '0;
            db_out    <= RESET_LEVEL;
            db_change <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            db_out    <= db_d;
            db_change <= chg_d;
        end
    end

`ifdef GLITCH_COUNT_EN
    // Clear wins over a same-cycle abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              glitch_cnt <= '0;
        else if (glitch_clr)                     glitch_cnt <= '0;
        else if (abort && glitch_cnt != GLITCH_MAX) glitch_cnt <= glitch_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer (TICK_DIV=4, STABLE_TICKS=3) plus a STABLE_TICKS=1 instance.
module tb_input_debouncer;

    typedef struct {
        int   cyc;
        logic lvl;
    } chg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0, din1 = 1'b0;
    logic db_out, tick, db_change;
    logic db_out1, tick1, db_change1;
`ifdef GLITCH_COUNT_EN
    logic       glitch_clr = 1'b0;
    logic [7:0] glitch_cnt, glitch_cnt1;
`endif

    int   total = 0, bad = 0, cyc = 0;
    logic lvl = 1'b0;
    chg_t q0[$], q1[$];

    always #5 clk = ~clk;

    input_debouncer #(.TICK_DIV(4), .STABLE_TICKS(3), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .din_async(din),
`ifdef GLITCH_COUNT_EN
        .glitch_clr(glitch_clr), .glitch_cnt(glitch_cnt),
`endif
        .db_out(db_out), .tick(tick), .db_change(db_change)
    );

    input_debouncer #(.TICK_DIV(4), .STABLE_TICKS(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din_async(din1),
`ifdef GLITCH_COUNT_EN
        .glitch_clr(glitch_clr), .glitch_cnt(glitch_cnt1),
`endif
        .db_out(db_out1), .tick(tick1), .db_change(db_change1)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expected change whenever a DUT pulses db_change.
    always @(negedge clk) begin
        chg_t e;
        if (!rst_n) begin
            lvl = 1'b0;
        end else begin
            chk("tick", tick, (cyc > 0 && cyc % 4 == 0));
            if (db_change) begin
                if (q0.size() == 0) chk("unexpected_db_change", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("change_cycle", cyc, e.cyc);
                    chk("change_level", db_out, e.lvl);
                    lvl = e.lvl;
                end
            end else begin
                chk("db_out_hold", db_out, lvl);
            end
            if (db_change1) begin
                if (q1.size() == 0) chk("unexpected_db_change1", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("st1_change_cycle", cyc, e.cyc);
                    chk("st1_change_level", db_out1, e.lvl);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc != n) begin
            @(negedge clk);
            g++;
            if (g > 5000) begin
                $display("FAIL wait_cyc: timeout waiting for cycle %0d", n);
                $fatal(1, "timeout");
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_db_out", db_out, 0);
        chk("reset_tick", tick, 0);
        chk("reset_db_change", db_change, 0);
        rst_n = 1'b1;

        // STABLE_TICKS=1 instance: follows on the first tick seeing the new level.
        wait_cyc(20); din1 = 1'b1; q1.push_back('{25, 1'b1});
        wait_cyc(30); din1 = 1'b0; q1.push_back('{33, 1'b0});

        // Held rise: sync_q=1 from 42, ticks 44/48/52, change visible at 53.
        wait_cyc(40); din = 1'b1; q0.push_back('{53, 1'b1});
        wait_cyc(70); din = 1'b0; q0.push_back('{81, 1'b0});
        // Short pulse: CHECK on ticks 92/96, aborts at tick 100.
        wait_cyc(90); din = 1'b1;
        wait_cyc(95); din = 1'b0;
`ifdef GLITCH_COUNT_EN
        wait_cyc(105); chk("glitch_cnt_one", glitch_cnt, 1);
`endif
        wait_cyc(110); din = 1'b1; q0.push_back('{121, 1'b1});
        // Fall, then reset while CHECK holds cnt=2 (ticks 132, 136).
        wait_cyc(130); din = 1'b0;
        wait_cyc(138);
        rst_n = 1'b0;
        #1;
        chk("midcheck_rst_db_out", db_out, 0);
        chk("midcheck_rst_tick", tick, 0);
        chk("midcheck_rst_db_change", db_change, 0);
`ifdef GLITCH_COUNT_EN
        chk("midcheck_rst_glitch", glitch_cnt, 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(40);

`ifdef GLITCH_COUNT_EN
        for (int i = 0; i < 300; i++) begin
            din = 1'b1; repeat (6) @(negedge clk);
            din = 1'b0; repeat (10) @(negedge clk);
        end
        chk("glitch_saturate", glitch_cnt, 255);
        din = 1'b1; repeat (6) @(negedge clk);
        din = 1'b0; glitch_clr = 1'b1; repeat (10) @(negedge clk);
        glitch_clr = 1'b0;
        chk("glitch_clr_priority", glitch_cnt, 0);
`endif
        repeat (4) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
